// File: rtl/bg_fill.sv
// bg_fill -- background pattern generator for a pixel-write VGA adapter.
//
// When start is accepted, the block sweeps the whole frame in raster order.
// It emits one pixel write per clock: x increments every cycle, and y
// increments when x wraps. Each pixel is coloured by the selected pattern.
// The pattern inputs (mode, colour_a, colour_b) are captured when the fill
// starts, so they can change freely while a fill is running.
//
// Optional feature: define BG_FILL_ABORT_EN to add an abort input. Asserting
// abort during a fill returns the block to idle without a done pulse.
//
// Parameters:
//   H_RES, V_RES  frame size in pixels / rows
//   X_WIDTH       width of the x coordinate
//   Y_WIDTH       width of the y coordinate
//   COLOR_WIDTH   width of a colour value
//   TILE_LOG2     log2 of the pattern tile edge, in pixels
//
// Ports:
//   CLOCK_50  in   system clock; all state changes on its rising edge
//   resetn    in   synchronous active-low reset
//   abort     in   (BG_FILL_ABORT_EN only) cancel a running fill
//   start     in   fill request; only looked at while idle
//   mode      in   0 solid, 1 vertical stripes, 2 checkerboard, 3 solid
//   colour_a  in   primary colour
//   colour_b  in   secondary colour
//   x, y      out  registered pixel coordinate
//   colour    out  registered pixel colour
//   plot      out  registered pixel write strobe
//   busy      out  high while a fill is running
//   done      out  one-cycle pulse after the final pixel
module bg_fill #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int COLOR_WIDTH = 3,
  parameter int TILE_LOG2   = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
`ifdef BG_FILL_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [COLOR_WIDTH-1:0] colour_a,
  input  logic [COLOR_WIDTH-1:0] colour_b,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic [COLOR_WIDTH-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_RES - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_RES - 1);

  state_t                 state_reg, state_next;
  logic [X_WIDTH-1:0]     x_reg, x_next;
  logic [Y_WIDTH-1:0]     y_reg, y_next;
  logic [COLOR_WIDTH-1:0] colour_reg, colour_next;
  logic                   plot_reg, plot_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic [1:0]             mode_reg, mode_next;
  logic [COLOR_WIDTH-1:0] colour_a_reg, colour_a_next;
  logic [COLOR_WIDTH-1:0] colour_b_reg, colour_b_next;

  // Pixel about to be presented, and the pattern settings used to colour it.
  logic [X_WIDTH-1:0]     adv_x;
  logic [Y_WIDTH-1:0]     adv_y;
  logic [1:0]             src_mode;
  logic [COLOR_WIDTH-1:0] src_a;
  logic [COLOR_WIDTH-1:0] src_b;
  logic                   sel_b;
  logic [COLOR_WIDTH-1:0] pix_colour;
  logic                   last_pixel;

  assign last_pixel = (x_reg == X_LAST) && (y_reg == Y_LAST);

  // On the accept cycle the latched settings are not yet loaded, so the
  // first pixel is coloured straight from the inputs. After that, only the
  // latched copies are used.
  always_comb begin
    adv_x    = '0;
    adv_y    = '0;
    src_mode = mode_reg;
    src_a    = colour_a_reg;
    src_b    = colour_b_reg;
    if (state_reg == IDLE) begin
      src_mode = mode;
      src_a    = colour_a;
      src_b    = colour_b;
    end else if (x_reg == X_LAST) begin
      adv_y = y_reg + Y_WIDTH'(1);
    end else begin
      adv_x = x_reg + X_WIDTH'(1);
      adv_y = y_reg;
    end
  end

  // Bit TILE_LOG2 of a coordinate is bit 0 of its tile index.
  always_comb begin
    sel_b = 1'b0;
    case (src_mode)
      2'd1:    sel_b = adv_x[TILE_LOG2];
      2'd2:    sel_b = adv_x[TILE_LOG2] ^ adv_y[TILE_LOG2];
      default: sel_b = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLOR_WIDTH; gi++) begin : g_colour_mux
      assign pix_colour[gi] = sel_b ? src_b[gi] : src_a[gi];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    colour_next   = colour_reg;
    plot_next     = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    mode_next     = mode_reg;
    colour_a_next = colour_a_reg;
    colour_b_next = colour_b_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = FILL;
          mode_next     = mode;
          colour_a_next = colour_a;
          colour_b_next = colour_b;
          x_next        = adv_x;
          y_next        = adv_y;
          colour_next   = pix_colour;
          plot_next     = 1'b1;
          busy_next     = 1'b1;
        end
      end
      FILL: begin
`ifdef BG_FILL_ABORT_EN
        // Abort wins over the final-pixel transition: no done pulse.
        if (abort) begin
          state_next = IDLE;
        end else
`endif
        if (last_pixel) begin
          // x/y keep the final pixel through DONE.
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          x_next      = adv_x;
          y_next      = adv_y;
          colour_next = pix_colour;
          plot_next   = 1'b1;
          busy_next   = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      colour_reg   <= '0;
      plot_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mode_reg     <= '0;
      colour_a_reg <= '0;
      colour_b_reg <= '0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      colour_reg   <= colour_next;
      plot_reg     <= plot_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      mode_reg     <= mode_next;
      colour_a_reg <= colour_a_next;
      colour_b_reg <= colour_b_next;
    end
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_bg_fill.sv
// Testbench for bg_fill (default 160x120 frame, 3-bit colour, 8-pixel tiles).
// Stimulus pushes the expected pixel stream of each accepted fill into a
// queue; the monitor pops and compares on every plot strobe.
module tb_bg_fill;
  localparam int H = 160;
  localparam int V = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] ca = 3'd0;
  logic [2:0] cb = 3'd0;
`ifdef BG_FILL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  bg_fill dut (
    .CLOCK_50(clk),
    .resetn(resetn),
`ifdef BG_FILL_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .mode(mode),
    .colour_a(ca),
    .colour_b(cb),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .done(done)
  );

  pix_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fill_plots = 0;
  int         done_cnt = 0;
  int         first_plot_cyc = -1;
  int         last_plot_cyc = -1;
  int         done_cyc = -1;
  int         sixes = 0;
  logic [14:0] first_xy = '1;
  logic [2:0] seen [H][V];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired at cycle %0d", name, cyc);
  endtask

  // Reference pattern: stripes/checks change every 8 pixels.
  task automatic push_fill(input logic [1:0] m, input logic [2:0] a, input logic [2:0] b);
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        logic sb;
        pix_t p;
        case (m)
          2'd1:    sb = ((xx / 8) % 2) == 1;
          2'd2:    sb = (((xx / 8) + (yy / 8)) % 2) == 1;
          default: sb = 1'b0;
        endcase
        p.x = 8'(xx);
        p.y = 7'(yy);
        p.c = sb ? b : a;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic clear_stats();
    fill_plots     = 0;
    done_cnt       = 0;
    sixes          = 0;
    first_plot_cyc = -1;
    last_plot_cyc  = -1;
    done_cyc       = -1;
    first_xy       = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_plots(input int n, input int budget, input string name);
    int k = 0;
    while (fill_plots < n && k < budget) begin
      tick();
      k++;
    end
    if (fill_plots < n) fail_now(name);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (done !== 1'b1) fail_now(name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pix_t e;
    if (plot === 1'b1) begin
      fill_plots++;
      if (fill_plots == 1) begin
        first_plot_cyc = cyc;
        first_xy = {x, y};
      end
      last_plot_cyc = cyc;
      if (colour == 3'd6) sixes++;
      if (x < H && y < V) seen[x][y] = colour;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got plot at x=%0d y=%0d expected no plot", x, y);
      end else begin
        e = exp_q.pop_front();
        chk("pixel{busy,x,y,colour}", {13'd0, busy, x, y, colour}, {13'd0, 1'b1, e});
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    int s;
    int p_before;
    int d_before;
    int rows[3];
    rows[0] = 0;
    rows[1] = 60;
    rows[2] = 119;

    // Reset state, with start held high to show it is not taken in reset.
    resetn = 1'b0;
    start  = 1'b1;
    repeat (3) tick();
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_colour", 32'(colour), 32'd0);
    chk("reset_plot", 32'(plot), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) tick();
    chk("idle_plot", 32'(plot), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Fill 1: solid 3'b101, with a stray start pulse at pixel 500.
    mode = 2'd0; ca = 3'b101; cb = 3'b010;
    push_fill(2'd0, 3'b101, 3'b010);
    clear_stats();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    wait_plots(500, 1000, "solid_reach_500");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20000, "solid_done");
    chk("done_plot", 32'(plot), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_hold_x", 32'(x), 32'd159);
    chk("done_hold_y", 32'(y), 32'd119);
    repeat (3) tick();
    chk("solid_plots", 32'(fill_plots), 32'd19200);
    chk("solid_done_count", 32'(done_cnt), 32'd1);
    chk("solid_first_latency", 32'(first_plot_cyc - s), 32'd1);
    chk("solid_first_xy", 32'(first_xy), 32'd0);
    chk("solid_done_after_last", 32'(done_cyc - last_plot_cyc), 32'd1);
    chk("solid_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("solid_last_colour", 32'(seen[159][119]), 32'd5);
    $display("fill solid: plots=%0d done=%0d checks=%0d errors=%0d", fill_plots, done_cnt, checks, errors);

    // Fill 2: stripes a=1 b=2; colour_a changes to 6 mid-fill; start stays
    // high through DONE so a second fill follows.
    mode = 2'd1; ca = 3'd1; cb = 3'd2;
    push_fill(2'd1, 3'd1, 3'd2);
    clear_stats();
    start = 1'b1;
    tick();
    wait_plots(100, 1000, "stripe_reach_100");
    ca = 3'd6;
    wait_done(20000, "stripe_done");
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("stripe_x7_y%0d", rows[r]), 32'(seen[7][rows[r]]), 32'd1);
      chk($sformatf("stripe_x8_y%0d", rows[r]), 32'(seen[8][rows[r]]), 32'd2);
      chk($sformatf("stripe_x16_y%0d", rows[r]), 32'(seen[16][rows[r]]), 32'd1);
    end
    chk("stripe_no_colour6", 32'(sixes), 32'd0);
    chk("stripe_plots", 32'(fill_plots), 32'd19200);
    chk("stripe_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("fill stripes: plots=%0d sixes=%0d checks=%0d errors=%0d", fill_plots, sixes, checks, errors);

    // Second fill latches the new colour_a; reset it at pixel 1000.
    push_fill(2'd1, 3'd6, 3'd2);
    s = cyc;
    fill_plots = 0;
    first_plot_cyc = -1;
    first_xy = '1;
    tick();
    tick();
    start = 1'b0;
    wait_plots(1000, 2000, "restart_reach_1000");
    chk("restart_latency", 32'(first_plot_cyc - s), 32'd2);
    chk("restart_first_xy", 32'(first_xy), 32'd0);
    chk("stripe_single_done", 32'(done_cnt), 32'd1);
    d_before = done_cnt;
    resetn = 1'b0;
    tick();
    chk("midreset_plot", 32'(plot), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    p_before = fill_plots;
    repeat (5) tick();
    chk("midreset_no_more_plots", 32'(fill_plots), 32'(p_before));
    chk("midreset_no_done", 32'(done_cnt), 32'(d_before));
    $display("reset mid-fill: plots=%0d checks=%0d errors=%0d", fill_plots, checks, errors);

    // Fill 3: checkerboard a=0 b=7 after the reset.
    mode = 2'd2; ca = 3'd0; cb = 3'd7;
    push_fill(2'd2, 3'd0, 3'd7);
    clear_stats();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    wait_done(20000, "checker_done");
    repeat (3) tick();
    chk("checker_first_latency", 32'(first_plot_cyc - s), 32'd1);
    chk("checker_first_xy", 32'(first_xy), 32'd0);
    chk("checker_plots", 32'(fill_plots), 32'd19200);
    chk("checker_done_count", 32'(done_cnt), 32'd1);
    chk("checker_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("checker_8_0", 32'(seen[8][0]), 32'd7);
    chk("checker_8_8", 32'(seen[8][8]), 32'd0);
    chk("checker_0_0", 32'(seen[0][0]), 32'd0);
    chk("checker_159_119", 32'(seen[159][119]), 32'd7);
    $display("fill checker: plots=%0d done=%0d checks=%0d errors=%0d", fill_plots, done_cnt, checks, errors);

`ifdef BG_FILL_ABORT_EN
    // Abort during the 50th pixel.
    mode = 2'd0; ca = 3'd3; cb = 3'd4;
    push_fill(2'd0, 3'd3, 3'd4);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_plots(49, 200, "abort_reach_49");
    abort = 1'b1;
    tick();
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    abort = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    chk("abort_plots", 32'(fill_plots), 32'd50);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    $display("fill abort: plots=%0d checks=%0d errors=%0d", fill_plots, checks, errors);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
